// File: rtl/ds_mode_ctrl.sv
// ============================================================================
// Module  : ds_mode_ctrl
// Brief   : Frame-synchronous mode/gray controller for the downscaler. It can
//           optionally mute output for whole frames after each commit
//           (enabled by the DS_CTRL_FLUSH_EN macro).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ds_mode_ctrl #(
    parameter logic [2:0]  DEF_MODE     = 3'd0,
    parameter logic        DEF_GRAY     = 1'b0,
    parameter int unsigned FLUSH_FRAMES = 1,
    parameter int unsigned FCNT_W       = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_vsync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_mode,
    input  logic              cfg_gray,
    output logic [2:0]        o_mode,
    output logic              o_gray,
    output logic              o_mute,
    output logic              o_busy,
    output logic              o_err,
    output logic [FCNT_W-1:0] o_frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [FCNT_W-1:0] c_FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               vs_d_q;
    logic [2:0]         pend_mode_q, pend_mode_d;
    logic               pend_gray_q, pend_gray_d;
    logic [2:0]         mode_q, mode_d;
    logic               gray_q, gray_d;
    logic               err_q, err_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic               w_vs_rise;

`ifdef DS_CTRL_FLUSH_EN
    localparam logic [3:0] c_FLUSH_INIT = FLUSH_FRAMES[3:0];
    logic               mute_q, mute_d;
    logic [3:0]         flush_cnt_q, flush_cnt_d;
`endif

    assign w_vs_rise = i_vsync & ~vs_d_q;

    always_comb begin
        state_d     = state_q;
        pend_mode_d = pend_mode_q;
        pend_gray_d = pend_gray_q;
        mode_d      = mode_q;
        gray_d      = gray_q;
        err_d       = 1'b0;
        frame_cnt_d = w_vs_rise ? (frame_cnt_q + c_FCNT_ONE) : frame_cnt_q;
`ifdef DS_CTRL_FLUSH_EN
        mute_d      = mute_q;
        flush_cnt_d = flush_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Modes 6/7 complete the handshake but are dropped with an error pulse
                if (cfg_valid) begin
                    if (cfg_mode <= 3'd5) begin
                        pend_mode_d = cfg_mode;
                        pend_gray_d = cfg_gray;
                        state_d     = S_PEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PEND: begin
                if (w_vs_rise) begin
                    mode_d = pend_mode_q;
                    gray_d = pend_gray_q;
`ifdef DS_CTRL_FLUSH_EN
                    mute_d      = 1'b1;
                    flush_cnt_d = c_FLUSH_INIT;
                    state_d     = S_FLUSH;
`else
                    state_d     = S_IDLE;
`endif
                end
            end
`ifdef DS_CTRL_FLUSH_EN
            S_FLUSH: begin
                if (w_vs_rise) begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    if (flush_cnt_q == 4'd1) begin
                        mute_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            vs_d_q      <= 1'b0;
            pend_mode_q <= 3'd0;
            pend_gray_q <= 1'b0;
            mode_q      <= DEF_MODE;
            gray_q      <= DEF_GRAY;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            vs_d_q      <= i_vsync;
            pend_mode_q <= pend_mode_d;
            pend_gray_q <= pend_gray_d;
            mode_q      <= mode_d;
            gray_q      <= gray_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef DS_CTRL_FLUSH_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mute_q      <= 1'b0;
            flush_cnt_q <= 4'd0;
        end else begin
            mute_q      <= mute_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_mute = mute_q;
`else
    assign o_mute = 1'b0;
`endif

    assign cfg_ready   = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_mode      = mode_q;
    assign o_gray      = gray_q;
    assign o_err       = err_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire
